// File: rtl/text_fetch.sv
// Text-mode fetch pipeline: walks the character cells of the display RAM, looks up
// glyph rows in the font ROM and serialises them into pixel colours, 3 clk behind vis_i.
module text_fetch #(
  parameter int COLS   = 80,
  parameter int FONT_H = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vis_i,
  input  logic              eol_i,
  input  logic              eof_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [15:0]       rd_data_i,
  output logic [11:0]       font_addr_o,
  input  logic [7:0]        font_data_i,
  output logic [3:0]        color_o,
  output logic              vis_o
);

  localparam logic [3:0]        SCAN_LAST = 4'(FONT_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(1);

  // Raster position
  logic [2:0]        pix_x;
  logic [ADDR_W-1:0] col;
  logic [3:0]        scan;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] frame_base;

  // Pipeline state
  logic        cell_start;
  logic [3:0]  rd_scan;
  logic        fetch_vld;
  logic        load_vld;
  logic [3:0]  fcolor_q;
  logic [3:0]  bcolor_q;
  logic [7:0]  glyph_q;
  logic [3:0]  cur_fcolor;
  logic [3:0]  cur_bcolor;
  logic [2:0]  vis_pipe;

  assign cell_start = vis_i && (pix_x == 3'd0);

  // eof_i outranks eol_i, which outranks pixel advance.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_x      <= '0;
      col        <= '0;
      scan       <= '0;
      line_base  <= '0;
      frame_base <= '0;
    end else if (eof_i) begin
      pix_x      <= '0;
      col        <= '0;
      scan       <= '0;
      frame_base <= base_addr_i;
      line_base  <= base_addr_i;
    end else if (eol_i) begin
      pix_x <= '0;
      col   <= '0;
      if (scan == SCAN_LAST) begin
        scan      <= '0;
        line_base <= line_base + ROW_STEP;
      end else begin
        scan <= scan + 4'd1;
      end
    end else if (vis_i) begin
      pix_x <= pix_x + 3'd1;
      if (pix_x == 3'd7) col <= col + COL_STEP;
    end
  end

  // Stage 1: cell read; the scanline travels with the read so a later eol_i cannot skew it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_scan   <= '0;
    end else begin
      rd_en_o <= cell_start;
      if (cell_start) begin
        rd_addr_o <= line_base + col;
        rd_scan   <= scan;
      end
    end
  end

  // Stage 2: cell word arrives; colours latched, glyph row addressed straight from the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_vld <= 1'b0;
      load_vld  <= 1'b0;
      fcolor_q  <= '0;
      bcolor_q  <= '0;
    end else begin
      fetch_vld <= rd_en_o;
      load_vld  <= fetch_vld;
      if (fetch_vld) begin
        bcolor_q <= rd_data_i[15:12];
        fcolor_q <= rd_data_i[11:8];
      end
    end
  end

  assign font_addr_o = fetch_vld ? {rd_data_i[7:0], rd_scan} : 12'h000;

  // Stage 3: the load cycle always carries the cell's first active pixel, which takes
  // font_data_i[7] directly, so the register is loaded already advanced by one bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vis_pipe   <= '0;
      glyph_q    <= '0;
      cur_fcolor <= '0;
      cur_bcolor <= '0;
    end else begin
      vis_pipe <= {vis_pipe[1:0], vis_i};
      if (load_vld) begin
        glyph_q    <= {font_data_i[6:0], 1'b0};
        cur_fcolor <= fcolor_q;
        cur_bcolor <= bcolor_q;
      end else if (vis_o) begin
        glyph_q <= {glyph_q[6:0], 1'b0};
      end
    end
  end

  assign vis_o = vis_pipe[2];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    color_o = 4'h0;
    if (vis_o) begin
      if (load_vld) color_o = font_data_i[7] ? fcolor_q : bcolor_q;
      else          color_o = glyph_q[7]     ? cur_fcolor : cur_bcolor;
    end
  end

  // The first row of a frame starts where the captured frame base says.
  frame_base_a: assert property (@(posedge clk) disable iff (reset)
    eof_i |=> (line_base == frame_base));

endmodule

// File: tb/tb_text_fetch.sv
// Self-checking bench for text_fetch: directed cells with a scoreboard of expected
// reads, font addresses and pixels, checked by a monitor on the falling edge.
module tb_text_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        vis_i, eol_i, eof_i;
  logic [11:0] base_addr_i;
  logic        rd_en_o;
  logic [11:0] rd_addr_o;
  logic [15:0] rd_data_i;
  logic [11:0] font_addr_o;
  logic [7:0]  font_data_i;
  logic [3:0]  color_o;
  logic        vis_o;

  text_fetch #(.COLS(80), .FONT_H(16), .ADDR_W(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .vis_i       (vis_i),
    .eol_i       (eol_i),
    .eof_i       (eof_i),
    .base_addr_i (base_addr_i),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .font_addr_o (font_addr_o),
    .font_data_i (font_data_i),
    .color_o     (color_o),
    .vis_o       (vis_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous display RAM and font ROM models
  logic [15:0] ram  [4096];
  logic [7:0]  font [4096];
  always @(posedge clk) if (rd_en_o) rd_data_i <= ram[rd_addr_o];
  always @(posedge clk) font_data_i <= font[font_addr_o];

  typedef struct { int cyc; logic [11:0] addr; logic [11:0] font; } rd_exp_t;
  typedef struct { int cyc; logic [3:0] color; } px_exp_t;
  rd_exp_t rq[$];
  px_exp_t pq[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor
  rd_exp_t     mon_rd;
  px_exp_t     mon_px;
  logic        fa_pend = 1'b0;
  logic [11:0] fa_exp;

  always @(negedge clk) begin
    if (reset) begin
      rq.delete();
      pq.delete();
      fa_pend = 1'b0;
    end else begin
      if (fa_pend) begin
        check("font_addr", font_addr_o, fa_exp);
        fa_pend = 1'b0;
      end
      if (rd_en_o) begin
        if (rq.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_read: got read of %0h, none expected (cycle %0d)", rd_addr_o, cyc);
        end else begin
          mon_rd = rq.pop_front();
          check("rd_cycle", cyc, mon_rd.cyc);
          check("rd_addr", rd_addr_o, mon_rd.addr);
          fa_pend = 1'b1;
          fa_exp  = mon_rd.font;
        end
      end
      if (vis_o) begin
        if (pq.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_pixel: got vis_o with color %0h, none expected (cycle %0d)", color_o, cyc);
        end else begin
          mon_px = pq.pop_front();
          check("pix_cycle", cyc, mon_px.cyc);
          check("pix_color", color_o, mon_px.color);
        end
      end else begin
        check("idle_color", color_o, 4'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vis_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse(input logic eof, input logic eol, input logic [11:0] base);
    vis_i       = 1'b0;
    eof_i       = eof;
    eol_i       = eol;
    base_addr_i = base;
    tick();
    eof_i = 1'b0;
    eol_i = 1'b0;
  endtask

  // Drives one cell at the hand-given address/scanline; expectations come from the
  // bench's own memory contents.
  task automatic drive_cell(input logic [11:0] addr, input logic [3:0] scan,
                            input int npix = 8, input int gap_at = 8, input int gap_len = 0);
    logic [15:0] w;
    logic [7:0]  g;
    w = ram[addr];
    g = font[{w[7:0], scan}];
    for (int i = 0; i < npix; i++) begin
      if (i == gap_at) idle(gap_len);
      vis_i = 1'b1;
      if (i == 0) rq.push_back('{cyc + 1, addr, {w[7:0], scan}});
      pq.push_back('{cyc + 3, g[7-i] ? w[11:8] : w[15:12]});
      tick();
    end
    vis_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 4096; a++) begin
      ram[a]  = 16'(a * 40503 + 7);
      font[a] = 8'(a * 37) ^ 8'h5C;
    end
    ram[0]         = 16'h1241;
    font[12'h410]  = 8'hF0;
    ram[1]         = 16'h7733;

    reset = 1'b1; vis_i = 1'b0; eol_i = 1'b0; eof_i = 1'b0; base_addr_i = '0;
    tick();
    tick();
    check("rst_rd_en", rd_en_o, 1'b0);
    check("rst_rd_addr", rd_addr_o, 12'h000);
    check("rst_font_addr", font_addr_o, 12'h000);
    check("rst_vis", vis_o, 1'b0);
    check("rst_color", color_o, 4'h0);
    reset = 1'b0;
    tick();

    // Frame at base 0: 'A' cell (2222_1111) then a cell with fcolor == bcolor == 7
    pulse(1'b1, 1'b0, 12'h000);
    drive_cell(12'h000, 4'd0);
    drive_cell(12'h001, 4'd0);
    idle(2);
    pulse(1'b0, 1'b1, 12'h000);

    // Scanlines 1..15, then the next cell row begins at 80
    for (int s = 1; s < 16; s++) begin
      drive_cell(12'h000, 4'(s));
      idle(2);
      pulse(1'b0, 1'b1, 12'h000);
    end
    drive_cell(12'h050, 4'd0);
    idle(2);
    pulse(1'b0, 1'b1, 12'h000);

    // Frame base near the top of the address space: second row wraps to 0x040
    pulse(1'b1, 1'b0, 12'hFF0);
    for (int s = 0; s < 16; s++) begin
      drive_cell(12'hFF0, 4'(s));
      if (s == 0) drive_cell(12'hFF1, 4'd0);
      idle(2);
      pulse(1'b0, 1'b1, 12'hFF0);
    end
    drive_cell(12'h040, 4'd0);
    drive_cell(12'h041, 4'd0);
    idle(2);
    pulse(1'b0, 1'b1, 12'hFF0);

    // Simultaneous eof/eol with scan at 2: eol is dropped, new base applies
    pulse(1'b0, 1'b1, 12'hFF0);
    pulse(1'b1, 1'b1, 12'h123);
    drive_cell(12'h123, 4'd0);
    idle(2);

    // Base change without eof is ignored; a mid-cell vis gap issues no extra read
    base_addr_i = 12'h500;
    idle(2);
    pulse(1'b0, 1'b1, 12'h500);
    drive_cell(12'h123, 4'd1, 8, 4, 3);
    idle(2);
    pulse(1'b0, 1'b1, 12'h500);

    // Asynchronous reset while a read and a pixel are both in flight
    drive_cell(12'h123, 4'd2);
    drive_cell(12'h124, 4'd2, 1);
    #2;
    check("pre_rst_rd_en", rd_en_o, 1'b1);
    check("pre_rst_vis", vis_o, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_rd_en", rd_en_o, 1'b0);
    check("async_rst_vis", vis_o, 1'b0);
    check("async_rst_color", color_o, 4'h0);
    check("async_rst_font_addr", font_addr_o, 12'h000);
    check("async_rst_rd_addr", rd_addr_o, 12'h000);
    tick();
    tick();
    #2;
    reset = 1'b0;
    tick();
    idle(3);
    drive_cell(12'h000, 4'd0);
    idle(6);

    check("rd_queue_drained", rq.size(), 0);
    check("pix_queue_drained", pq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
